// File: rtl/led_blink_multi_if.sv
// Configuration write bus for led_blink_multi: one strobe plus channel, mode, period and burst.
interface led_blink_multi_if #(
  parameter int unsigned CNT_W = 26
);
  logic             cfg_we;
  logic [3:0]       cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_period;
  logic [7:0]       cfg_burst;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_mode,
    output cfg_period,
    output cfg_burst
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_mode,
    input cfg_period,
    input cfg_burst
  );
endinterface

// File: rtl/led_blink_multi.sv
// Multi-channel LED driver with OFF/ON/BLINK modes; define LED_BURST_EN to add
// BURST mode (N blink pulses then OFF) together with the per-channel done pulses.
module led_blink_multi #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned DEFAULT_HALF = 5000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  led_blink_multi_if.slave    cfg,
  output logic [CHANNELS-1:0] LED,
  output logic [CHANNELS-1:0] done
);

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeBlink = 2'd2,
    ModeBurst = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [CNT_W-1:0] HalfReset = (DEFAULT_HALF == 0) ? CntOne : CNT_W'(DEFAULT_HALF);

  mode_e               mode_q [CHANNELS];
  mode_e               mode_d [CHANNELS];
  logic [CNT_W-1:0]    half_q [CHANNELS];
  logic [CNT_W-1:0]    half_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] led_q, led_d;
  logic [CHANNELS-1:0] hit, wrap;
  logic [CNT_W-1:0]    wr_half;

`ifdef LED_BURST_EN
  logic [7:0]          rem_q [CHANNELS];
  logic [7:0]          rem_d [CHANNELS];
  logic [CHANNELS-1:0] done_q, done_d;
`else
  logic                unused_burst;
  assign unused_burst = ^cfg.cfg_burst;
`endif

  // A zero half-period behaves as one so the counter always has a valid wrap point.
  assign wr_half = (cfg.cfg_period == '0) ? CntOne : cfg.cfg_period;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i]  = cfg.cfg_we && (cfg.cfg_ch == 4'(i));
      wrap[i] = (cnt_q[i] >= half_q[i] - CntOne);
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i] = mode_q[i];
      half_d[i] = half_q[i];
      cnt_d[i]  = cnt_q[i];
      led_d[i]  = led_q[i];
`ifdef LED_BURST_EN
      rem_d[i]  = rem_q[i];
      done_d[i] = 1'b0;
`endif
      if (hit[i]) begin
        // A write overrides any toggle or burst completion due this cycle.
        half_d[i] = wr_half;
        cnt_d[i]  = '0;
        led_d[i]  = 1'b0;
        case (mode_e'(cfg.cfg_mode))
          ModeOn: begin
            mode_d[i] = ModeOn;
            led_d[i]  = 1'b1;
          end
          ModeBlink: mode_d[i] = ModeBlink;
`ifdef LED_BURST_EN
          ModeBurst: begin
            rem_d[i]  = cfg.cfg_burst;
            mode_d[i] = (cfg.cfg_burst == 8'd0) ? ModeOff : ModeBurst;
            done_d[i] = (cfg.cfg_burst == 8'd0);
          end
`endif
          default: mode_d[i] = ModeOff;
        endcase
      end else begin
        case (mode_q[i])
          ModeOn: begin
            cnt_d[i] = '0;
            led_d[i] = 1'b1;
          end
          ModeBlink: begin
            if (wrap[i]) begin
              cnt_d[i] = '0;
              led_d[i] = ~led_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CntOne;
            end
          end
`ifdef LED_BURST_EN
          ModeBurst: begin
            if (wrap[i]) begin
              cnt_d[i] = '0;
              led_d[i] = ~led_q[i];
              // Each falling edge consumes one pulse; the last one ends the burst.
              if (led_q[i]) begin
                if (rem_q[i] <= 8'd1) begin
                  rem_d[i]  = 8'd0;
                  mode_d[i] = ModeOff;
                  done_d[i] = 1'b1;
                end else begin
                  rem_d[i] = rem_q[i] - 8'd1;
                end
              end
            end else begin
              cnt_d[i] = cnt_q[i] + CntOne;
            end
          end
`endif
          default: begin
            cnt_d[i] = '0;
            led_d[i] = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i] <= ModeBlink;
        half_q[i] <= HalfReset;
        cnt_q[i]  <= '0;
`ifdef LED_BURST_EN
        rem_q[i]  <= 8'd0;
`endif
      end
      led_q <= '0;
`ifdef LED_BURST_EN
      done_q <= '0;
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i] <= mode_d[i];
        half_q[i] <= half_d[i];
        cnt_q[i]  <= cnt_d[i];
`ifdef LED_BURST_EN
        rem_q[i]  <= rem_d[i];
`endif
      end
      led_q <= led_d;
`ifdef LED_BURST_EN
      done_q <= done_d;
`endif
    end
  end

  assign LED = led_q;
`ifdef LED_BURST_EN
  assign done = done_q;
`else
  assign done = '0;
`endif

endmodule
